exp_host_if: RTL



---
 rtl/exp_host_if_pkg.sv | 32 +++
 rtl/exp_host_if_if.sv | 31 +++
 rtl/exp_host_if.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exp_host_if_pkg.sv
// ---------------------------------------------------------------------------
// exp_host_if_pkg
// Shared constants, FSM state encoding and the exponent-length acceptance
// rule for the exponentiation-engine host interface.
// Ports: none (package).
// ---------------------------------------------------------------------------
package exp_host_if_pkg;

    localparam int WORD_W       = 64;
    localparam int OP_W         = 1024;
    localparam int WORDS_PER_OP = 16;
    localparam int NUM_OPS      = 5;
    localparam int LOAD_WORDS   = 81;
    localparam int MAX_LENE     = 1024;

    localparam int K_W = 7;     // load word index, 0..80
    localparam int J_W = 4;     // result word index, 0..15

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CHECK = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    // An exponent length is usable only if it is non-zero and fits in one operand.
    function automatic logic lene_ok(input logic [31:0] lene);
        return (lene != 32'd0) && (lene <= 32'(MAX_LENE));
    endfunction

endpackage

// File: rtl/exp_host_if_if.sv
// ---------------------------------------------------------------------------
// exp_host_if_if
// Host-side streaming bus: 64-bit operand words in, 64-bit result words out,
// both with valid/ready handshakes.
//   in_valid/in_ready/in_data      host -> block operand words
//   out_valid/out_ready/out_data   block -> host result words
//   out_last                       marks the 16th result word
// Modports: master = host side, slave = exp_host_if side.
// ---------------------------------------------------------------------------
interface exp_host_if_if;
    import exp_host_if_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/exp_host_if.sv
// ---------------------------------------------------------------------------
// exp_host_if
// Collects 81 host words (five 1024-bit operands x, m, e, r, r2, LSW first,
// then the exponent length), validates the length, starts the modular
// exponentiation engine, times the job and streams the 1024-bit result back
// as 16 words.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   host                    host stream bus (slave modport)
//   o_eng_x..o_eng_r2       operands to engine, stable from START until LOAD
//   o_eng_lene              exponent length to engine
//   o_eng_start             one-cycle engine start pulse
//   i_eng_result/i_eng_done engine result, sampled in the done cycle
//   o_busy                  high whenever not in LOAD
//   o_err                   one-cycle pulse when the exponent length is rejected
//   o_cycle_count           START-to-done cycle count of the last job (saturating)
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | accept host words 0..80 into operand / length registers
// CHECK   | validate exponent length; reject -> err pulse, back to LOAD
// START   | pulse eng_start, clear cycle counter
// WAIT    | count cycles until eng_done, capture result
// SEND    | stream result words 0..15 to host, out_last on word 15
// ---------------------------------------------------------------------------
module exp_host_if
    import exp_host_if_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    exp_host_if_if.slave     host,
    output logic [OP_W-1:0]  o_eng_x,
    output logic [OP_W-1:0]  o_eng_m,
    output logic [OP_W-1:0]  o_eng_e,
    output logic [OP_W-1:0]  o_eng_r,
    output logic [OP_W-1:0]  o_eng_r2,
    output logic [31:0]      o_eng_lene,
    output logic             o_eng_start,
    input  logic [OP_W-1:0]  i_eng_result,
    input  logic             i_eng_done,
    output logic             o_busy,
    output logic             o_err,
    output logic [31:0]      o_cycle_count
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [K_W-1:0]                 r_k;
    logic [J_W-1:0]                 r_j;
    logic [NUM_OPS-1:0][OP_W-1:0]   r_ops;
    logic [OP_W-1:0]                r_result;
    logic [31:0]                    r_lene;
    logic [31:0]                    r_cycle_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_eng_start;
    logic w_err;
    logic w_in_hs;
    logic w_out_hs;
    logic w_last_in;
    logic w_last_out;

    // Handshakes are derived from state directly so they do not loop through
    // the combinational output block.
    assign w_in_hs    = host.in_valid  && (r_state == ST_LOAD);
    assign w_out_hs   = host.out_ready && (r_state == ST_SEND);
    assign w_last_in  = (r_k == K_W'(LOAD_WORDS - 1));
    assign w_last_out = (r_j == J_W'(WORDS_PER_OP - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_eng_start = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (w_in_hs && w_last_in) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (lene_ok(r_lene)) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_START: begin
                w_eng_start = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_eng_done) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_out_valid = 1'b1;
                if (w_out_hs && w_last_out) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_LOAD;
            r_k           <= '0;
            r_j           <= '0;
            r_ops         <= '0;
            r_result      <= '0;
            r_lene        <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_in_hs) begin
                // Words 0..79 fill operands 16 words at a time; word 80 is the length.
                if (w_last_in) begin
                    r_lene <= host.in_data[31:0];
                end else begin
                    r_ops[r_k[6:4]][r_k[3:0]*WORD_W +: WORD_W] <= host.in_data;
                end
                r_k <= r_k + 1'b1;
            end

            if ((r_state == ST_CHECK) && !lene_ok(r_lene)) begin
                r_k <= '0;
            end

            if (r_state == ST_START) begin
                r_cycle_count <= '0;
            end

            if (r_state == ST_WAIT) begin
                if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
                if (i_eng_done) r_result <= i_eng_result;
            end

            if (w_out_hs) begin
                if (w_last_out) begin
                    r_j <= '0;
                    r_k <= '0;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign host.in_ready  = w_in_ready;
    assign host.out_valid = w_out_valid;
    assign host.out_data  = r_result[r_j*WORD_W +: WORD_W];
    assign host.out_last  = w_out_valid && w_last_out;

    assign o_eng_x       = r_ops[0];
    assign o_eng_m       = r_ops[1];
    assign o_eng_e       = r_ops[2];
    assign o_eng_r       = r_ops[3];
    assign o_eng_r2      = r_ops[4];
    assign o_eng_lene    = r_lene;
    assign o_eng_start   = w_eng_start;
    assign o_busy        = (r_state != ST_LOAD);
    assign o_err         = w_err;
    assign o_cycle_count = r_cycle_count;

endmodule
